// File: rtl/hk_mash_pkg.sv
// Shared types and constants for the HK-MASH configuration sequencer.
// The LFSR constants are only consumed when HK_MASH_DITHER_EN is defined.
package hk_mash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_JUMP   = 2'd1,
        ST_RAMP   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int word_w(input int int_w, input int frac_w);
        return int_w + frac_w;
    endfunction

endpackage

// File: rtl/hk_mash_lfsr.sv
// 16-bit Fibonacci LFSR used to dither the LSB of the fractional word.
// Resets to the seed; advances on en_i; load_i reloads the seed synchronously.
module hk_mash_lfsr
    import hk_mash_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        load_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (en_i) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/hk_mash_ctrl.sv
// Configuration sequencer for the HK-MASH DDSM: applies {int,frac} words as a jump or a ramp.
// Optional LSB dither of frac_o is enabled by defining HK_MASH_DITHER_EN.
module hk_mash_ctrl
    import hk_mash_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int INT_W  = 8,
    parameter int STEP_W = 16,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [INT_W-1:0]  cfg_int_i,
    input  logic [WIDTH-1:0]  cfg_frac_i,
    input  logic [STEP_W-1:0] cfg_step_i,
    output logic [INT_W-1:0]  int_o,
    output logic [WIDTH-1:0]  frac_o,
    output logic              mash_clr_o,
    output logic              busy_o,
    output logic              lock_o
);

    localparam int WW    = word_w(INT_W, WIDTH);
    localparam int CNT_W = $clog2(SETTLE + 1);

    // Handshake: a configuration transfers on a rising edge where cfg_valid_i and
    // cfg_ready_o are both high; the requester holds valid and data until then.
    state_e            state_q, state_d;
    logic [WW-1:0]     cur_q, cur_d;
    logic [WW-1:0]     tgt_q, tgt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clr_q, clr_d;
    logic              lock_q, lock_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic [WW-1:0]     diff;
    logic [WW-1:0]     step_ext;

    assign accept   = cfg_valid_i & ready_q;
    assign step_ext = WW'(step_q);
    assign diff     = (tgt_q > cur_q) ? (tgt_q - cur_q) : (cur_q - tgt_q);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        clr_d   = 1'b0;
        lock_d  = lock_q;
        if (accept) begin
            // A new word takes priority over a coincident update strobe
            tgt_d   = {cfg_int_i, cfg_frac_i};
            step_d  = cfg_step_i;
            lock_d  = 1'b0;
            cnt_d   = '0;
            state_d = (cfg_step_i == '0) ? ST_JUMP : ST_RAMP;
        end else if (en_i) begin
            case (state_q)
                ST_JUMP: begin
                    cur_d   = tgt_q;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                ST_RAMP: begin
                    // Snap when within one step so the ramp never overshoots or wraps
                    if (diff <= step_ext) begin
                        cur_d   = tgt_q;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end else if (tgt_q > cur_q) begin
                        cur_d = cur_q + step_ext;
                    end else begin
                        cur_d = cur_q - step_ext;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        lock_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        ready_d = (state_d == ST_IDLE) || (state_d == ST_SETTLE);
        busy_d  = (state_d == ST_JUMP) || (state_d == ST_RAMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            lock_q  <= lock_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign int_o       = cur_q[WW-1:WIDTH];
    assign mash_clr_o  = clr_q;
    assign busy_o      = busy_q;
    assign lock_o      = lock_q;

`ifdef HK_MASH_DITHER_EN
    logic [15:0] lfsr;

    hk_mash_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .load_i (1'b0),
        .lfsr_o (lfsr)
    );

    assign frac_o = {cur_q[WIDTH-1:1], cur_q[0] ^ lfsr[0]};
`else
    assign frac_o = cur_q[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_hk_mash_ctrl.sv
// Directed self-checking bench for hk_mash_ctrl in its default (undithered) build.
module tb_hk_mash_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [7:0]  cfg_int_i = '0;
  logic [23:0] cfg_frac_i = '0;
  logic [15:0] cfg_step_i = '0;
  logic [7:0]  int_o;
  logic [23:0] frac_o;
  logic        mash_clr_o;
  logic        busy_o;
  logic        lock_o;

  int n_chk  = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  logic [31:0] exp_q[$];

  hk_mash_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_int_i   (cfg_int_i),
    .cfg_frac_i  (cfg_frac_i),
    .cfg_step_i  (cfg_step_i),
    .int_o       (int_o),
    .frac_o      (frac_o),
    .mash_clr_o  (mash_clr_o),
    .busy_o      (busy_o),
    .lock_o      (lock_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mash_clr_o) clr_cnt++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input logic en);
    en_i = en;
    @(posedge clk);
    #1;
    en_i = 1'b0;
  endtask

  task automatic en_after_gap(input int gap);
    repeat (gap) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic send_cfg(input logic [7:0] i, input logic [23:0] f, input logic [15:0] s,
                          input logic en);
    chk("send_ready", {31'd0, cfg_ready_o}, 32'd1);
    cfg_valid_i = 1'b1;
    cfg_int_i   = i;
    cfg_frac_i  = f;
    cfg_step_i  = s;
    cyc(en);
    cfg_valid_i = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_int"},   {24'd0, int_o}, 32'd0);
    chk({tag, "_frac"},  {8'd0, frac_o}, 32'd0);
    chk({tag, "_clr"},   {31'd0, mash_clr_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    chk({tag, "_lock"},  {31'd0, lock_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, cfg_ready_o}, 32'd1);
  endtask

  // Settle window: lock must rise exactly on the 4th strobe
  task automatic settle_expect_lock(input string tag);
    for (int k = 1; k <= 4; k++) begin
      en_after_gap(1);
      chk({tag, "_lock"}, {31'd0, lock_o}, (k == 4) ? 32'd1 : 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset then idle with en_i every cycle
    #1;
    en_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("rst");
    rst = 1'b0;
    repeat (4) cyc(1'b1);
    chk_idle_zero("idle");

    // 2. jump to 40 + 0x400000, en_i every 4th cycle
    clr_cnt = 0;
    send_cfg(8'd40, 24'h400000, 16'h0, 1'b0);
    chk("jmp_busy", {31'd0, busy_o}, 32'd1);
    chk("jmp_ready", {31'd0, cfg_ready_o}, 32'd0);
    repeat (3) cyc(1'b0);
    chk("jmp_hold_int", {24'd0, int_o}, 32'd0);
    cyc(1'b1);
    chk("jmp_int", {24'd0, int_o}, 32'd40);
    chk("jmp_frac", {8'd0, frac_o}, 32'h400000);
    chk("jmp_clr_now", {31'd0, mash_clr_o}, 32'd1);
    chk("jmp_busy_off", {31'd0, busy_o}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      en_after_gap(3);
      chk("jmp_lock", {31'd0, lock_o}, (k == 4) ? 32'd1 : 32'd0);
    end
    chk("jmp_clr_count", clr_cnt, 32'd1);

    // 3. ramp up 40.25 -> 40 + 0x420000, step 0x8000
    clr_cnt = 0;
    send_cfg(8'd40, 24'h420000, 16'h8000, 1'b0);
    chk("up_lock_drop", {31'd0, lock_o}, 32'd0);
    exp_q = '{32'h408000, 32'h410000, 32'h418000, 32'h420000};
    for (int k = 0; k < 4; k++) begin
      en_after_gap(1);
      chk("up_frac", {8'd0, frac_o}, exp_q.pop_front());
      chk("up_int", {24'd0, int_o}, 32'd40);
      chk("up_busy", {31'd0, busy_o}, (k == 3) ? 32'd0 : 32'd1);
    end
    settle_expect_lock("up");
    chk("up_no_clr", clr_cnt, 32'd0);

    // 4. ramp down from 0x000100 to 0 with step 0x30
    send_cfg(8'd0, 24'h000100, 16'h0, 1'b0);
    cyc(1'b1);
    settle_expect_lock("pre_dn");
    chk("pre_dn_frac", {8'd0, frac_o}, 32'h100);
    send_cfg(8'd0, 24'h000000, 16'h0030, 1'b0);
    exp_q = '{32'hD0, 32'hA0, 32'h70, 32'h40, 32'h10, 32'h0};
    for (int k = 0; k < 6; k++) begin
      en_after_gap(0);
      chk("dn_frac", {8'd0, frac_o}, exp_q.pop_front());
      chk("dn_int", {24'd0, int_o}, 32'd0);
    end
    chk("dn_busy_off", {31'd0, busy_o}, 32'd0);
    cyc(1'b1);
    chk("dn_floor", {8'd0, frac_o}, 32'd0);

    // 5. backpressure during ramp, then retarget in SETTLE
    send_cfg(8'd0, 24'h000300, 16'h0100, 1'b0);
    cyc(1'b1);
    chk("bp_frac1", {8'd0, frac_o}, 32'h100);
    cfg_valid_i = 1'b1;
    cfg_int_i   = 8'd99;
    cfg_frac_i  = 24'h0;
    cfg_step_i  = 16'h0;
    cyc(1'b0);
    chk("bp_ready", {31'd0, cfg_ready_o}, 32'd0);
    chk("bp_busy", {31'd0, busy_o}, 32'd1);
    cyc(1'b1);
    cfg_valid_i = 1'b0;
    chk("bp_no_accept_int", {24'd0, int_o}, 32'd0);
    chk("bp_frac2", {8'd0, frac_o}, 32'h200);
    cyc(1'b1);
    chk("bp_snap", {8'd0, frac_o}, 32'h300);
    chk("bp_clr_none", {31'd0, mash_clr_o}, 32'd0);
    cyc(1'b1);
    cyc(1'b1);
    chk("rt_lock_pre", {31'd0, lock_o}, 32'd0);
    send_cfg(8'd0, 24'h000400, 16'h0100, 1'b1);
    chk("rt_frac_hold", {8'd0, frac_o}, 32'h300);
    chk("rt_busy", {31'd0, busy_o}, 32'd1);
    chk("rt_lock", {31'd0, lock_o}, 32'd0);
    cyc(1'b1);
    chk("rt_snap", {8'd0, frac_o}, 32'h400);
    settle_expect_lock("rt");

    // 6. asynchronous reset between clock edges during a ramp
    send_cfg(8'd3, 24'h001000, 16'h0100, 1'b0);
    cyc(1'b1);
    cyc(1'b1);
    chk("ar_busy_pre", {31'd0, busy_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_zero("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cyc(1'b1);
    chk_idle_zero("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
